// File: rtl/aes_inv_iter.sv
// Iterative AES-128 decryption core.
// One inverse-round datapath is reused for all ten rounds.
// The state register drives plaintext_o directly.

// Combinational AES inverse S-box.
// The inverse affine transform is applied first.
// It is followed by the multiplicative inverse in GF(2^8), computed as x^254.
module inv_s_box (
  input  logic [7:0] a,
  output logic [7:0] y
);

  function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] z);
    logic [7:0] p;
    logic [7:0] t;
    p = 8'h00;
    t = x;
    for (int i = 0; i < 8; i++) begin
      if (z[i]) p = p ^ t;
      t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // x^254 = x^240 * x^12 * x^2; zero maps to zero as the S-box requires
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240;
    x2   = gf_mul(x, x);
    x3   = gf_mul(x2, x);
    x6   = gf_mul(x3, x3);
    x12  = gf_mul(x6, x6);
    x15  = gf_mul(x12, x3);
    x30  = gf_mul(x15, x15);
    x60  = gf_mul(x30, x30);
    x120 = gf_mul(x60, x60);
    x240 = gf_mul(x120, x120);
    return gf_mul(gf_mul(x240, x12), x2);
  endfunction

  logic [7:0] b;

  // inverse affine map (rotations by 1, 3, 6 plus 0x05), then field inverse
  always_comb begin
    b = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
    y = gf_inv(b);
  end

endmodule

module aes_inv_iter (
  input  logic         clk,
  input  logic         rst,
  input  logic         valid_i,
  output logic         ready_o,
  input  logic [127:0] ciphertext_i,
  input  logic [127:0] round_key_i [10:0],
  output logic         valid_o,
  input  logic         ready_i,
  output logic [127:0] plaintext_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e       state_q, state_d;
  logic [127:0] blk_q, blk_d;
  logic [3:0]   rnd_q, rnd_d;

  logic [127:0] isr;
  logic [127:0] isb;
  logic [127:0] ark;
  logic [127:0] imc;

  function automatic logic [7:0] xt(input logic [7:0] v);
    return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
  endfunction

  // One InvMixColumns column; 9/b/d/e are built from the x2, x4, x8 chain
  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a [4];
    logic [7:0] m2 [4];
    logic [7:0] m4 [4];
    logic [7:0] m8 [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    for (int i = 0; i < 4; i++) begin
      a[i]  = col[31-8*i -: 8];
      m2[i] = xt(a[i]);
      m4[i] = xt(m2[i]);
      m8[i] = xt(m4[i]);
      m9[i] = m8[i] ^ a[i];
      mb[i] = m8[i] ^ m2[i] ^ a[i];
      md[i] = m8[i] ^ m4[i] ^ a[i];
      me[i] = m8[i] ^ m4[i] ^ m2[i];
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  // InvShiftRows: row r of column c takes the byte from column (c - r) mod 4
  always_comb begin
    isr = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        isr[127-8*(4*c+r) -: 8] = blk_q[127-8*(4*((c-r+4)%4)+r) -: 8];
      end
    end
  end

  for (genvar g = 0; g < 16; g++) begin : g_isb
    inv_s_box u_isb (
      .a (isr[127-8*g -: 8]),
      .y (isb[127-8*g -: 8])
    );
  end

  // Round-key add, then InvMixColumns, which the final round bypasses
  always_comb begin
    ark = isb ^ round_key_i[rnd_q];
    imc = '0;
    for (int c = 0; c < 4; c++) begin
      imc[127-32*c -: 32] = inv_mix_col(ark[127-32*c -: 32]);
    end
  end

  // Next-state, block and round-counter update
  always_comb begin
    state_d = state_q;
    blk_d   = blk_q;
    rnd_d   = rnd_q;
    case (state_q)
      IDLE: begin
        if (valid_i) begin
          blk_d   = ciphertext_i ^ round_key_i[10];
          rnd_d   = 4'd9;
          state_d = ROUND;
        end
      end
      ROUND: begin
        if (rnd_q != 4'd0) begin
          blk_d = imc;
          rnd_d = rnd_q - 4'd1;
        end else begin
          blk_d   = ark;
          state_d = DONE;
        end
      end
      DONE: begin
        if (ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset clears the block so no partial result is exposed
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      blk_q   <= '0;
      rnd_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      blk_q   <= blk_d;
      rnd_q   <= rnd_d;
    end
  end

  assign ready_o     = (state_q == IDLE);
  assign valid_o     = (state_q == DONE);
  assign plaintext_o = blk_q;

endmodule

// File: doc/aes_inv_iter.md
# aes_inv_iter

Iterative AES-128 decryption core: accepts one 128-bit ciphertext block over a valid/ready handshake and performs one inverse round per clock. After 10 inverse rounds it presents the plaintext over a second valid/ready handshake. It sits on the receive side of the datapath as the counterpart of the pipelined `aes` encryptor. It consumes the same 11-entry round-key array that the encryptor uses and is area-optimised: one inverse-round datapath, reused.

## Interface
Parameters:
- none (AES-128 only; Nr = 10 is fixed)

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `valid_i`  in  1  `ciphertext_i` is valid
- `ready_o`  out  1  core can accept a block; high only in IDLE
- `ciphertext_i`  in  128  input block
- `round_key_i[10:0]`  in  128 each  expanded key schedule
  - `[0]` is the cipher key; `[10]` is the last encryption round key
  - must be held stable from the accept edge until the output handshake completes
- `valid_o`  out  1  `plaintext_o` is valid; high only in DONE
- `ready_i`  in  1  downstream accepts `plaintext_o`
- `plaintext_o`  out  128  decrypted block, driven directly from the state register

Byte order:
- bits [127:120] = byte 0 (FIPS-197 s0,0)
- byte k occupies [127-8k -: 8]
- column c = bytes 4c..4c+3, column-major, identical to the encryptor

## Operation
FSM states:
- IDLE
  - `ready_o`=1
  - on `valid_i`&`ready_o`: state ← `ciphertext_i` ^ `round_key_i[10]`; rnd ← 9; go to ROUND
- ROUND
  - rnd ≠ 0: state ← InvMixColumns(AddRoundKey(InvSubBytes(InvShiftRows(state)), `round_key_i[rnd]`)); rnd ← rnd−1
  - rnd = 0: state ← AddRoundKey(InvSubBytes(InvShiftRows(state)), `round_key_i[0]`); go to DONE (no InvMixColumns)
- DONE
  - `valid_o`=1; state and `plaintext_o` are frozen
  - on `ready_i`: go to IDLE

Datapath and control:
- rnd is a 4-bit down-counter. It is only meaningful in ROUND; in the other states it holds its value.
- InvSubBytes uses 16 parallel instances of a combinational inverse S-box (separate `inv_s_box` module).
- InvMixColumns uses GF(2^8) xtime chains; coefficients are 0e/0b/0d/09 mod x^8+x^4+x^3+x+1.
- `valid_i` while not in IDLE is ignored. The block is not captured, and the source must hold it until `ready_o`.
- `valid_o` does not depend combinationally on `ready_i`.
- `ready_o` is registered state decode; there is no combinational path from any input.

Reset:
- `rst`=1 at an edge forces IDLE, state=0, rnd=0.
- Resulting outputs: `ready_o`=1, `valid_o`=0, `plaintext_o`=0.
- Reset has priority over every transition. A mid-operation reset discards the in-flight block with no partial output.

## Timing
- Accept edge E0: IDLE→ROUND with rnd=9.
- Edges E1..E10 perform the 10 inverse rounds. E10 (rnd=0) moves to DONE.
- `valid_o` is high from after E10. Latency is 10 cycles from the accept edge to `valid_o` rising.
- Output handshake at edge Eh (`ready_i`=1 in DONE): DONE→IDLE, so `ready_o` is high from after Eh.
- If `ready_i` is high on the first DONE cycle, Eh = E11. The next accept is then at E12 at the earliest, so peak throughput is one block per 12 cycles.
- `ready_i` low in DONE: `valid_o` and `plaintext_o` hold indefinitely.
- `valid_i` and `ready_i` may both be high in the same cycle in DONE. Only the output handshake occurs; the input is accepted in IDLE on a later cycle.
- Critical path: InvShiftRows → inverse S-box → key XOR → InvMixColumns.

## Test plan
- FIPS-197 App. B vector.
  - Stimulus: key 2b7e151628aed2a6abf7158809cf4f3c (expanded), ct 3925841d02dc09fbdc118597196a0b32, `ready_i`=1.
  - Required: `plaintext_o`=3243f6a8885a308d313198a2e0370734 with `valid_o` rising exactly 10 cycles after accept, and high for exactly 1 cycle.
- FIPS-197 C.1 vector.
  - Stimulus: key 000102…0f, ct 69c4e0d86a7b0430d8cdb78070b4c55a.
  - Required: pt 00112233445566778899aabbccddeeff. Also check the state after E1 against the spec's round[1] ioutput value.
- Backpressure.
  - Stimulus: C.1 vector with `ready_i`=0 for 7 cycles after `valid_o`.
  - Required: `valid_o`=1 and `plaintext_o` stable all 7 cycles; `ready_o`=0 throughout; IDLE on the cycle after `ready_i`=1.
- Busy input.
  - Stimulus: new ciphertext with `valid_i`=1 during ROUND.
  - Required: result equals the first block's plaintext; the second block is accepted only after return to IDLE and decrypts correctly.
- Reset mid-operation.
  - Stimulus: assert `rst` for 1 cycle when rnd=5.
  - Required: next cycle `ready_o`=1, `valid_o`=0, `plaintext_o`=0; a fresh App. B block then decrypts correctly.
- Loopback.
  - Stimulus: 200 random key/plaintext pairs through `aes` → `aes_inv_iter`, with random `ready_i` throttling.
  - Required: every output equals the original plaintext, in order.
